// File: rtl/cdb_arbiter_pkg.sv
// Shared Tomasulo types: CDB sizing constants and the broadcast word layout.
package tomasula_types;

  localparam int unsigned rob_tag_width = 5;
  localparam int unsigned num_cdb_req   = 6;
  localparam int unsigned cdb_src_width = 3;
  // Requester slot that carries a branch outcome (resbr).
  localparam int unsigned br_req_idx    = 4;

  typedef struct packed {
    logic                     valid;
    logic [rob_tag_width-1:0] tag;
    logic [31:0]              data;
    logic [cdb_src_width-1:0] src;
    logic                     br_taken;
  } cdb_word;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
// Purely combinational so it can be shared by other arbiters.
module rr_picker #(
  parameter int unsigned N = 6,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned cand;
    logic        hit;
    gnt  = '0;
    idx  = '0;
    hit  = 1'b0;
    cand = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(ptr) + i) % N;
      if (!hit && req[cand]) begin
        hit       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = W'(cand);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among result producers,
// registered one-cycle broadcast, flush squash and a busy-cycle counter.
module cdb_arbiter
  import tomasula_types::*;
#(
  parameter int unsigned NUM_REQ = num_cdb_req,
  parameter int unsigned TAG_W   = rob_tag_width
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag_i,
  input  logic [NUM_REQ-1:0][31:0]       req_data_i,
  input  logic                           req_br_taken_i,
  input  logic                           flush_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic                           cdb_valid_o,
  output logic [TAG_W-1:0]               cdb_tag_o,
  output logic [31:0]                    cdb_data_o,
  output logic [cdb_src_width-1:0]       cdb_src_o,
  output logic                           cdb_br_taken_o,
  output logic [31:0]                    busy_cnt_o
);

  logic [cdb_src_width-1:0] rr_ptr;
  logic [cdb_src_width-1:0] win;
  logic [cdb_src_width-1:0] ptr_next;
  logic [NUM_REQ-1:0]       req_eff;
  logic                     any_gnt;
  logic                     valid_q;

  // Flush and reset both hide every request, so no grant can leak out.
  always_comb begin
    req_eff = req_i & {NUM_REQ{reset_n_i & ~flush_i}};
  end

  rr_picker #(
    .N (NUM_REQ),
    .W (cdb_src_width)
  ) u_picker (
    .req (req_eff),
    .ptr (rr_ptr),
    .gnt (gnt_o),
    .idx (win)
  );

  // Pointer advances to the slot after the winner, wrapping at NUM_REQ.
  always_comb begin
    any_gnt  = |gnt_o;
    ptr_next = (32'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  end

  // A flush also kills the broadcast already registered from last cycle.
  always_comb begin
    cdb_valid_o = valid_q & ~flush_i;
  end

  // Broadcast register, round-robin pointer and busy counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr         <= '0;
      valid_q        <= 1'b0;
      cdb_tag_o      <= '0;
      cdb_data_o     <= '0;
      cdb_src_o      <= '0;
      cdb_br_taken_o <= 1'b0;
      busy_cnt_o     <= '0;
    end else begin
      valid_q <= any_gnt;
      if (any_gnt) begin
        rr_ptr         <= ptr_next;
        cdb_tag_o      <= req_tag_i[win];
        cdb_data_o     <= req_data_i[win];
        cdb_src_o      <= win;
        cdb_br_taken_o <= req_br_taken_i & (32'(win) == br_req_idx);
      end
      if (cdb_valid_o) begin
        busy_cnt_o <= busy_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expectations.
module tb_cdb_arbiter;
  import tomasula_types::*;

  localparam int unsigned N  = 6;
  localparam int unsigned TW = rob_tag_width;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [N-1:0]             req;
  logic [N-1:0][TW-1:0]     req_tag;
  logic [N-1:0][31:0]       req_data;
  logic                     br;
  logic                     flush;
  logic [N-1:0]             gnt;
  logic                     valid;
  logic [TW-1:0]            tag;
  logic [31:0]              data;
  logic [cdb_src_width-1:0] src;
  logic                     br_out;
  logic [31:0]              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .NUM_REQ (N),
    .TAG_W   (TW)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (rst_n),
    .req_i          (req),
    .req_tag_i      (req_tag),
    .req_data_i     (req_data),
    .req_br_taken_i (br),
    .flush_i        (flush),
    .gnt_o          (gnt),
    .cdb_valid_o    (valid),
    .cdb_tag_o      (tag),
    .cdb_data_o     (data),
    .cdb_src_o      (src),
    .cdb_br_taken_o (br_out),
    .busy_cnt_o     (busy)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_tag  = '0;
    req_data = '0;
    br       = 1'b0;
    flush    = 1'b0;

    // Reset state; grants suppressed even with all requests high
    #2;
    req = '1;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_src", 32'(src), 32'h0);
    req = '0;
    step();
    step();
    rst_n = 1'b1;

    // Single request from requester 0
    req_tag[0]  = TW'(3);
    req_data[0] = 32'hDEADBEEF;
    req         = 6'b000001;
    #1;
    chk("single_gnt", 32'(gnt), 32'h1);
    step();
    req = '0;
    chk("single_valid", 32'(valid), 32'h1);
    chk("single_tag", 32'(tag), 32'h3);
    chk("single_data", data, 32'hDEADBEEF);
    chk("single_src", 32'(src), 32'h0);
    step();
    chk("idle_valid", 32'(valid), 32'h0);
    chk("idle_tag_hold", 32'(tag), 32'h3);
    chk("idle_data_hold", data, 32'hDEADBEEF);
    chk("idle_busy", busy, 32'h1);

    // All six requesting from reset: grants 0..5 then 0
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_tag[i]  = TW'(i + 8);
      req_data[i] = 32'h100 + 32'(i);
    end
    req = '1;
    #1;
    for (int k = 0; k < 7; k++) begin
      chk("rr_gnt", 32'(gnt), 32'h1 << (k % 6));
      step();
      chk("rr_valid", 32'(valid), 32'h1);
      chk("rr_src", 32'(src), 32'(k % 6));
      chk("rr_tag", 32'(tag), 32'((k % 6) + 8));
      chk("rr_data", data, 32'h100 + 32'(k % 6));
    end
    req = '0;

    // Branch grant from requester 4, then flush; pointer sits at 5
    br  = 1'b1;
    req = 6'b010000;
    #1;
    chk("br_gnt", 32'(gnt), 32'h10);
    step();
    flush = 1'b1;
    br    = 1'b0;
    req   = 6'b100001;
    #1;
    chk("flush_valid", 32'(valid), 32'h0);
    chk("flush_gnt", 32'(gnt), 32'h0);
    chk("flush_src", 32'(src), 32'h4);
    chk("flush_br", 32'(br_out), 32'h1);
    step();
    flush = 1'b0;
    #1;
    chk("post_flush_valid", 32'(valid), 32'h0);
    chk("wrap_gnt5", 32'(gnt), 32'h20);
    step();
    req = 6'b000001;
    #1;
    chk("wrap_valid5", 32'(valid), 32'h1);
    chk("wrap_src5", 32'(src), 32'h5);
    chk("wrap_data5", data, 32'h105);
    chk("wrap_gnt0", 32'(gnt), 32'h1);
    step();
    req = '0;
    chk("wrap_src0", 32'(src), 32'h0);
    chk("wrap_valid0", 32'(valid), 32'h1);
    chk("wrap_br0", 32'(br_out), 32'h0);
    step();

    // Ten back-to-back grants to requester 2
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req_data[2] = 32'hCAFE0002;
    req         = 6'b000100;
    repeat (10) step();
    req = '0;
    chk("busy9", busy, 32'd9);
    step();
    chk("busy10", busy, 32'd10);
    chk("busy10_valid", 32'(valid), 32'h0);

    // Reset mid-broadcast clears outputs without a clock edge
    req = 6'b100000;
    #1;
    chk("pre_rst_gnt", 32'(gnt), 32'h20);
    step();
    req = '0;
    chk("pre_rst_valid", 32'(valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(valid), 32'h0);
    chk("async_busy", busy, 32'h0);
    chk("async_src", 32'(src), 32'h0);
    chk("async_tag", 32'(tag), 32'h0);
    chk("async_data", data, 32'h0);
    req = 6'b100100;
    #1;
    chk("rst_hold_gnt", 32'(gnt), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_gnt", 32'(gnt), 32'h4);
    step();
    req = '0;
    chk("post_rst_src", 32'(src), 32'h2);
    chk("post_rst_valid", 32'(valid), 32'h1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
